mem_request_arbiter: RTL and testbench
======================================

# mem_request_arbiter

Parametrised memory request unit that collects load/store/fetch requests from NUM_CH CPU-side requestors and serialises them onto a single memory bus. Each granted request is held registered until the bus acknowledges it or a configurable timeout expires, then a one-cycle response is returned to the originating channel. It sits between the datapath ports (instruction fetch, data load/store, later DMA or debug) and the memory/cache interface. Fixed-priority and round-robin arbitration are both supported.

## Interface
Parameters:
- NUM_CH, 2, number of requestor channels (≥2); channel 0 is instruction fetch by convention
- ADDR_W, 32, address width
- DATA_W, 32, data width (multiple of 8)
- ARB_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
- TIMEOUT_CYC, 0, bus-ack timeout in cycles; 0 disables timeout

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- req_valid  in  NUM_CH  per-channel request, held until that channel's resp_valid
- req_wen  in  NUM_CH  1 = write, 0 = read
- req_addr  in  NUM_CH×ADDR_W  per-channel address
- req_wdata  in  NUM_CH×DATA_W  per-channel write data
- req_strb  in  NUM_CH×(DATA_W/8)  per-channel byte enables
- resp_valid  out  NUM_CH  one-cycle completion pulse, one-hot or zero
- resp_rdata  out  DATA_W  read data, shared across channels
- resp_err  out  1  qualifies resp_valid: timeout occurred
- bus_ren  out  1  memory read strobe
- bus_wen  out  1  memory write strobe
- bus_addr  out  ADDR_W  memory address
- bus_wdata  out  DATA_W  memory write data
- bus_strb  out  DATA_W/8  memory byte enables
- bus_ack  in  1  memory completion (read data valid on bus_rdata)
- bus_rdata  in  DATA_W  memory read data

## Operation
- FSM: IDLE → BUSY → RESP → IDLE.
- IDLE: if any req_valid, pick a winner and latch its wen, addr, wdata, strb and channel id into registers; go to BUSY. Otherwise stay in IDLE.
- BUSY: bus_ren = ~wen_q and bus_wen = wen_q, both driven from registers. bus_addr, bus_wdata and bus_strb are driven from registers.
  - On bus_ack, capture bus_rdata (0 for writes) and go to RESP.
- RESP: resp_valid[id_q] = 1, resp_rdata = captured data, resp_err = err_q. Go to IDLE.
- Fixed mode: lowest-index asserted req_valid wins.
- Round-robin mode: search starts at last_grant+1 mod NUM_CH. last_grant updates on every grant and resets to NUM_CH-1, so channel 0 wins first.
- Timeout (TIMEOUT_CYC>0): a counter clears on entry to BUSY and increments each BUSY cycle without ack. When the counter reaches TIMEOUT_CYC-1 without ack, go to RESP with err_q = 1 and rdata 0; strobes drop.
- If ack and timeout occur in the same cycle, ack wins and err_q = 0.
- bus_ack in IDLE or RESP is ignored.
- If a requestor drops req_valid while it is in service, the transaction still completes and resp_valid still pulses.
- bus_ren and bus_wen are never both 1.
- Outside BUSY: bus strobes are 0 and bus_addr/bus_wdata/bus_strb hold their last values.
- Id width CH_W = max(1, $clog2(NUM_CH)). Counter width = $clog2(TIMEOUT_CYC+1).

## Timing
- Reset (nRST = 0 at a CLK edge): state IDLE, all outputs 0, registers 0, last_grant = NUM_CH-1. Reset mid-transaction abandons it with no response.
- Request seen in IDLE at cycle t: strobe asserted at t+1. If bus_ack arrives at t+1+k (k ≥ 0), resp_valid is high at t+2+k and the next arbitration happens at t+3+k.
- Minimum issue interval per transaction: 3 cycles.
- Timeout: strobe is high for exactly TIMEOUT_CYC cycles, then resp_valid with resp_err = 1 in the following cycle.

## Structure
- cpu_pkg additions:
  - arb_state_t enum {IDLE, BUSY, RESP}
  - ARB_FIXED = 0, ARB_RR = 1 localparams
- Sub-module arb_pick: combinational one-hot and index picker over NUM_CH requests with a rotating base input (base forced to 0 in fixed mode).
- Top level holds the FSM, request registers, timeout counter and last_grant.

## Test plan
- NUM_CH=2, fixed mode: ch0 read 0x100 and ch1 write 0x200 asserted together, ack after 0 cycles each. Expect ch0 served first, resp_valid[0] at t+2, then ch1 bus_wen with addr 0x200 at t+4, resp_valid[1] at t+5.
- Round-robin, NUM_CH=4, all four requesting continuously. Expect grant order 0,1,2,3,0; each resp_valid one-hot.
- Read with ack delayed 3 cycles, bus_rdata = 0xDEADBEEF. Expect bus_ren high for 4 cycles and resp_rdata = 0xDEADBEEF, resp_err = 0.
- TIMEOUT_CYC=5, no ack. Expect strobe high for 5 cycles, then resp_valid with resp_err = 1 and resp_rdata = 0. Repeat with ack on the 5th cycle: expect resp_err = 0.
- Synchronous nRST asserted during BUSY. Expect all outputs 0 the next cycle, no resp_valid, and the next grant going to ch0 in round-robin mode.
- Spurious bus_ack in IDLE, and requestor dropping req_valid mid-BUSY. Expect the spurious ack to be ignored and the in-flight transaction to still complete with its resp_valid pulse.

Source files
------------

// File: rtl/mem_request_arbiter_pkg.sv
// Shared types and constants for the memory request arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE, BUSY, RESP)
//   ARB_FIXED   : fixed-priority arbitration, lowest channel index wins
//   ARB_RR      : round-robin arbitration starting after the last grant
//   width_min1  : $clog2 clamped to a minimum of one bit
package mem_request_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  localparam int unsigned ARB_FIXED = 0;
  localparam int unsigned ARB_RR    = 1;

  // Index/counter width that never collapses to zero bits.
  function automatic int unsigned width_min1(input int unsigned n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mem_request_arbiter_if.sv
// Requestor and memory-bus signal bundle for mem_request_arbiter.
//   master : arbiter view (drives bus_* and resp_*, receives req_* and bus_ack/bus_rdata)
//   slave  : environment view (requestors plus memory model)
//   req_*  : per-channel request payload, held until that channel's resp_valid
//   resp_* : one-cycle completion pulse with shared read data and timeout flag
//   bus_*  : single serialised memory port
interface mem_request_arbiter_if #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  localparam int unsigned STRB_W = DATA_W / 8;

  logic [NUM_CH-1:0]             req_valid;
  logic [NUM_CH-1:0]             req_wen;
  logic [NUM_CH-1:0][ADDR_W-1:0] req_addr;
  logic [NUM_CH-1:0][DATA_W-1:0] req_wdata;
  logic [NUM_CH-1:0][STRB_W-1:0] req_strb;

  logic [NUM_CH-1:0]             resp_valid;
  logic [DATA_W-1:0]             resp_rdata;
  logic                          resp_err;

  logic                          bus_ren;
  logic                          bus_wen;
  logic [ADDR_W-1:0]             bus_addr;
  logic [DATA_W-1:0]             bus_wdata;
  logic [STRB_W-1:0]             bus_strb;
  logic                          bus_ack;
  logic [DATA_W-1:0]             bus_rdata;

  modport master (
    input  req_valid, req_wen, req_addr, req_wdata, req_strb,
    output resp_valid, resp_rdata, resp_err,
    output bus_ren, bus_wen, bus_addr, bus_wdata, bus_strb,
    input  bus_ack, bus_rdata
  );

  modport slave (
    output req_valid, req_wen, req_addr, req_wdata, req_strb,
    input  resp_valid, resp_rdata, resp_err,
    input  bus_ren, bus_wen, bus_addr, bus_wdata, bus_strb,
    output bus_ack, bus_rdata
  );

endinterface

// File: rtl/mem_request_arbiter_arb_pick.sv
// Combinational first-set picker over NUM_CH requests, searching upward
// from a rotating base index and wrapping modulo NUM_CH.
//   req_i       : request vector
//   base_i      : first index examined (0 gives plain lowest-index priority)
//   gnt_oh_c_o  : one-hot winner, zero when nothing requests
//   gnt_idx_c_o : winner index
//   gnt_any_c_o : at least one request present
module mem_request_arbiter_arb_pick #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned CH_W   = 1
) (
  input  logic [NUM_CH-1:0] req_i,
  input  logic [CH_W-1:0]   base_i,
  output logic [NUM_CH-1:0] gnt_oh_c_o,
  output logic [CH_W-1:0]   gnt_idx_c_o,
  output logic              gnt_any_c_o
);

  logic [CH_W:0]   pos_c;
  logic [CH_W-1:0] idx_c;

  // Walk base, base+1, ... with wrap; the first requester found wins.
  always_comb begin
    gnt_oh_c_o  = '0;
    gnt_idx_c_o = '0;
    gnt_any_c_o = 1'b0;
    pos_c       = '0;
    idx_c       = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pos_c = {1'b0, base_i} + (CH_W+1)'(i);
      if (pos_c >= (CH_W+1)'(NUM_CH)) begin
        pos_c = pos_c - (CH_W+1)'(NUM_CH);
      end
      idx_c = pos_c[CH_W-1:0];
      if (!gnt_any_c_o && req_i[idx_c]) begin
        gnt_any_c_o        = 1'b1;
        gnt_oh_c_o[idx_c]  = 1'b1;
        gnt_idx_c_o        = idx_c;
      end
    end
  end

endmodule

// File: rtl/mem_request_arbiter.sv
// Serialises load/store/fetch requests from NUM_CH requestors onto one memory
// bus. A granted request is held in registers until bus_ack or timeout, then a
// one-cycle response is returned to the originating channel.
//   CLK    : clock
//   nRST   : synchronous active-low reset
//   bus_if : requestor, response and memory-bus signals (master view)
module mem_request_arbiter
  import mem_request_arbiter_pkg::*;
#(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ARB_MODE    = ARB_FIXED,
  parameter int unsigned TIMEOUT_CYC = 0
) (
  input  logic                 CLK,
  input  logic                 nRST,
  mem_request_arbiter_if.master bus_if
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam int unsigned CH_W   = width_min1(NUM_CH);
  localparam int unsigned CNT_W  = width_min1(TIMEOUT_CYC + 1);
  localparam bit          TO_EN  = (TIMEOUT_CYC != 0);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_BUSY = BUSY;
  localparam logic [1:0] ST_RESP = RESP;

  logic [1:0]        state_q,      state_d;
  logic [CH_W-1:0]   id_q,         id_d;
  logic [CH_W-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]  cnt_q,        cnt_d;
  logic              bus_ren_q,    bus_ren_d;
  logic              bus_wen_q,    bus_wen_d;
  logic [ADDR_W-1:0] bus_addr_q,   bus_addr_d;
  logic [DATA_W-1:0] bus_wdata_q,  bus_wdata_d;
  logic [STRB_W-1:0] bus_strb_q,   bus_strb_d;
  logic [NUM_CH-1:0] resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q,   resp_err_d;

  logic [CH_W-1:0]   rr_base_c;
  logic [CH_W-1:0]   pick_base_c;
  logic [NUM_CH-1:0] pick_oh_c;
  logic [CH_W-1:0]   pick_idx_c;
  logic              pick_any_c;
  logic              pick_wen_c;
  logic              timeout_c;

  // Round-robin search begins one past the last granted channel.
  assign rr_base_c   = (last_grant_q == CH_W'(NUM_CH - 1)) ? '0 : last_grant_q + CH_W'(1);
  assign pick_base_c = (ARB_MODE == ARB_RR) ? rr_base_c : '0;

  mem_request_arbiter_arb_pick #(
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_pick (
    .req_i       (bus_if.req_valid),
    .base_i      (pick_base_c),
    .gnt_oh_c_o  (pick_oh_c),
    .gnt_idx_c_o (pick_idx_c),
    .gnt_any_c_o (pick_any_c)
  );

  assign pick_wen_c = |(bus_if.req_wen & pick_oh_c);

  // Last BUSY cycle allowed without ack; counter starts at 0 on BUSY entry.
  assign timeout_c = TO_EN && (cnt_q == CNT_W'(TIMEOUT_CYC - 1));

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    id_d         = id_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    bus_ren_d    = bus_ren_q;
    bus_wen_d    = bus_wen_q;
    bus_addr_d   = bus_addr_q;
    bus_wdata_d  = bus_wdata_q;
    bus_strb_d   = bus_strb_q;
    resp_valid_d = '0;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any_c) begin
          state_d      = ST_BUSY;
          id_d         = pick_idx_c;
          last_grant_d = pick_idx_c;
          cnt_d        = '0;
          bus_wen_d    = pick_wen_c;
          bus_ren_d    = ~pick_wen_c;
          bus_addr_d   = bus_if.req_addr[pick_idx_c];
          bus_wdata_d  = bus_if.req_wdata[pick_idx_c];
          bus_strb_d   = bus_if.req_strb[pick_idx_c];
        end
      end

      ST_BUSY: begin
        // Ack takes precedence over a simultaneous timeout.
        if (bus_if.bus_ack) begin
          state_d          = ST_RESP;
          bus_ren_d        = 1'b0;
          bus_wen_d        = 1'b0;
          resp_valid_d[id_q] = 1'b1;
          resp_rdata_d     = bus_wen_q ? '0 : bus_if.bus_rdata;
          resp_err_d       = 1'b0;
        end else if (timeout_c) begin
          state_d          = ST_RESP;
          bus_ren_d        = 1'b0;
          bus_wen_d        = 1'b0;
          resp_valid_d[id_q] = 1'b1;
          resp_rdata_d     = '0;
          resp_err_d       = 1'b1;
        end else if (TO_EN) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any in-flight transaction.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q      <= ST_IDLE;
      id_q         <= '0;
      last_grant_q <= CH_W'(NUM_CH - 1);
      cnt_q        <= '0;
      bus_ren_q    <= 1'b0;
      bus_wen_q    <= 1'b0;
      bus_addr_q   <= '0;
      bus_wdata_q  <= '0;
      bus_strb_q   <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      id_q         <= id_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      bus_ren_q    <= bus_ren_d;
      bus_wen_q    <= bus_wen_d;
      bus_addr_q   <= bus_addr_d;
      bus_wdata_q  <= bus_wdata_d;
      bus_strb_q   <= bus_strb_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  assign bus_if.bus_ren    = bus_ren_q;
  assign bus_if.bus_wen    = bus_wen_q;
  assign bus_if.bus_addr   = bus_addr_q;
  assign bus_if.bus_wdata  = bus_wdata_q;
  assign bus_if.bus_strb   = bus_strb_q;
  assign bus_if.resp_valid = resp_valid_q;
  assign bus_if.resp_rdata = resp_rdata_q;
  assign bus_if.resp_err   = resp_err_q;

endmodule

// File: tb/tb_mem_request_arbiter.sv
// Directed bench for mem_request_arbiter: a 2-channel fixed-priority instance
// without timeout and a 4-channel round-robin instance with TIMEOUT_CYC=5.
module tb_mem_request_arbiter;

  logic CLK;
  logic nRST;
  int unsigned errors;
  int unsigned checks;

  mem_request_arbiter_if #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32)) if_a ();
  mem_request_arbiter_if #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32)) if_b ();

  mem_request_arbiter #(
    .NUM_CH(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT_CYC(0)
  ) dut_a (
    .CLK    (CLK),
    .nRST   (nRST),
    .bus_if (if_a)
  );

  mem_request_arbiter #(
    .NUM_CH(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT_CYC(5)
  ) dut_b (
    .CLK    (CLK),
    .nRST   (nRST),
    .bus_if (if_b)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Advance one cycle; outputs are then stable and inputs may be changed.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [3:0]  exp_oh;
    logic [31:0] exp_addr;
    errors = 0;
    checks = 0;
    nRST = 1'b0;
    if_a.req_valid = '0; if_a.req_wen = '0; if_a.req_addr = '0;
    if_a.req_wdata = '0; if_a.req_strb = '0; if_a.bus_ack = 1'b0; if_a.bus_rdata = '0;
    if_b.req_valid = '0; if_b.req_wen = '0; if_b.req_addr = '0;
    if_b.req_wdata = '0; if_b.req_strb = '0; if_b.bus_ack = 1'b0; if_b.bus_rdata = '0;

    // Reset state
    step(); step();
    check("rst_a_ren",   64'(if_a.bus_ren), 64'd0);
    check("rst_a_wen",   64'(if_a.bus_wen), 64'd0);
    check("rst_a_addr",  64'(if_a.bus_addr), 64'd0);
    check("rst_a_rv",    64'(if_a.resp_valid), 64'd0);
    check("rst_b_rv",    64'(if_b.resp_valid), 64'd0);
    check("rst_b_err",   64'(if_b.resp_err), 64'd0);
    nRST = 1'b1;

    // Fixed priority: ch0 read and ch1 write together, immediate ack
    if_a.req_valid = 2'b11;
    if_a.req_wen   = 2'b10;
    if_a.req_addr[0] = 32'h100;  if_a.req_addr[1] = 32'h200;
    if_a.req_wdata[0] = 32'h0BAD0BAD; if_a.req_wdata[1] = 32'hCAFE0001;
    if_a.req_strb[0] = 4'hF; if_a.req_strb[1] = 4'h3;
    if_a.bus_ack = 1'b1;
    if_a.bus_rdata = 32'h11112222;
    step(); // t+1
    check("fx_t1_ren",  64'(if_a.bus_ren), 64'd1);
    check("fx_t1_wen",  64'(if_a.bus_wen), 64'd0);
    check("fx_t1_addr", 64'(if_a.bus_addr), 64'h100);
    step(); // t+2
    check("fx_t2_rv",    64'(if_a.resp_valid), 64'b01);
    check("fx_t2_rdata", 64'(if_a.resp_rdata), 64'h11112222);
    check("fx_t2_err",   64'(if_a.resp_err), 64'd0);
    check("fx_t2_ren",   64'(if_a.bus_ren), 64'd0);
    if_a.req_valid = 2'b10;
    step(); // t+3
    check("fx_t3_rv",  64'(if_a.resp_valid), 64'd0);
    check("fx_t3_wen", 64'(if_a.bus_wen), 64'd0);
    step(); // t+4
    check("fx_t4_wen",   64'(if_a.bus_wen), 64'd1);
    check("fx_t4_ren",   64'(if_a.bus_ren), 64'd0);
    check("fx_t4_addr",  64'(if_a.bus_addr), 64'h200);
    check("fx_t4_wdata", 64'(if_a.bus_wdata), 64'hCAFE0001);
    check("fx_t4_strb",  64'(if_a.bus_strb), 64'h3);
    step(); // t+5
    check("fx_t5_rv",    64'(if_a.resp_valid), 64'b10);
    check("fx_t5_rdata", 64'(if_a.resp_rdata), 64'd0);
    check("fx_t5_wen",   64'(if_a.bus_wen), 64'd0);
    if_a.req_valid = '0;
    if_a.bus_ack = 1'b0;
    step(); // idle, bus payload holds
    check("fx_hold_addr", 64'(if_a.bus_addr), 64'h200);
    check("fx_hold_rv",   64'(if_a.resp_valid), 64'd0);

    // Read with ack delayed 3 cycles
    if_a.req_valid = 2'b10;
    if_a.req_wen = 2'b00;
    if_a.req_addr[1] = 32'h300;
    if_a.bus_rdata = 32'hDEADBEEF;
    for (int i = 0; i < 4; i++) begin
      step();
      check("dly_ren", 64'(if_a.bus_ren), 64'd1);
      if (i == 3) if_a.bus_ack = 1'b1;
    end
    step();
    check("dly_rv",    64'(if_a.resp_valid), 64'b10);
    check("dly_rdata", 64'(if_a.resp_rdata), 64'hDEADBEEF);
    check("dly_err",   64'(if_a.resp_err), 64'd0);
    check("dly_ren_off", 64'(if_a.bus_ren), 64'd0);
    if_a.req_valid = '0;
    if_a.bus_ack = 1'b0;
    step();

    // Spurious ack in IDLE is ignored
    if_a.bus_ack = 1'b1;
    if_a.bus_rdata = 32'h0;
    step(); step();
    check("spur_rv",  64'(if_a.resp_valid), 64'd0);
    check("spur_ren", 64'(if_a.bus_ren), 64'd0);
    check("spur_wen", 64'(if_a.bus_wen), 64'd0);

    // Requestor drops req_valid mid-BUSY: transaction still completes
    if_a.bus_ack = 1'b0;
    if_a.req_valid = 2'b01;
    if_a.req_addr[0] = 32'h440;
    if_a.bus_rdata = 32'h600DF00D;
    step();
    check("drop_ren",  64'(if_a.bus_ren), 64'd1);
    check("drop_addr", 64'(if_a.bus_addr), 64'h440);
    if_a.req_valid = '0;
    step();
    check("drop_busy", 64'(if_a.bus_ren), 64'd1);
    if_a.bus_ack = 1'b1;
    step();
    check("drop_rv",    64'(if_a.resp_valid), 64'b01);
    check("drop_rdata", 64'(if_a.resp_rdata), 64'h600DF00D);
    if_a.bus_ack = 1'b0;
    step();
    check("drop_rv_off", 64'(if_a.resp_valid), 64'd0);

    // Round-robin with all four channels requesting continuously
    for (int ch = 0; ch < 4; ch++) if_b.req_addr[ch] = 32'h1000 + 32'(16 * ch);
    if_b.req_valid = 4'hF;
    if_b.req_wen = 4'h0;
    if_b.bus_ack = 1'b1;
    if_b.bus_rdata = 32'hA5A50000;
    for (int g = 0; g < 5; g++) begin
      exp_addr = 32'h1000 + 32'(16 * (g % 4));
      exp_oh = 4'b0001 << (g % 4);
      step();
      check("rr_addr", 64'(if_b.bus_addr), 64'(exp_addr));
      check("rr_ren",  64'(if_b.bus_ren), 64'd1);
      step();
      check("rr_rv",   64'(if_b.resp_valid), 64'(exp_oh));
      if (g == 4) if_b.req_valid = '0;
      step();
    end
    if_b.bus_ack = 1'b0;

    // Timeout without ack: strobe for 5 cycles then error response
    if_b.req_valid = 4'b0100;
    if_b.bus_rdata = 32'h55AA55AA;
    for (int i = 0; i < 5; i++) begin
      step();
      check("to_ren", 64'(if_b.bus_ren), 64'd1);
    end
    step();
    check("to_rv",    64'(if_b.resp_valid), 64'b0100);
    check("to_err",   64'(if_b.resp_err), 64'd1);
    check("to_rdata", 64'(if_b.resp_rdata), 64'd0);
    check("to_ren_off", 64'(if_b.bus_ren), 64'd0);
    if_b.req_valid = '0;
    step();
    check("to_err_off", 64'(if_b.resp_err), 64'd0);
    check("to_rv_off",  64'(if_b.resp_valid), 64'd0);

    // Ack on the final allowed cycle wins over timeout
    if_b.req_valid = 4'b1000;
    if_b.bus_rdata = 32'h12345678;
    for (int i = 0; i < 5; i++) begin
      step();
      check("toack_ren", 64'(if_b.bus_ren), 64'd1);
      if (i == 4) if_b.bus_ack = 1'b1;
    end
    step();
    check("toack_rv",    64'(if_b.resp_valid), 64'b1000);
    check("toack_err",   64'(if_b.resp_err), 64'd0);
    check("toack_rdata", 64'(if_b.resp_rdata), 64'h12345678);
    if_b.req_valid = '0;
    if_b.bus_ack = 1'b0;
    step();

    // Synchronous reset during BUSY abandons the transaction
    if_b.req_valid = 4'b0010;
    step();
    check("rb_ren",  64'(if_b.bus_ren), 64'd1);
    check("rb_addr", 64'(if_b.bus_addr), 64'h1010);
    nRST = 1'b0;
    step();
    check("rb_rst_ren",   64'(if_b.bus_ren), 64'd0);
    check("rb_rst_addr",  64'(if_b.bus_addr), 64'd0);
    check("rb_rst_rv",    64'(if_b.resp_valid), 64'd0);
    check("rb_rst_rdata", 64'(if_b.resp_rdata), 64'd0);
    check("rb_rst_err",   64'(if_b.resp_err), 64'd0);
    nRST = 1'b1;
    if_b.req_valid = 4'b0111;
    step();
    check("rb_grant_addr", 64'(if_b.bus_addr), 64'h1000);
    check("rb_grant_ren",  64'(if_b.bus_ren), 64'd1);
    check("rb_no_rv",      64'(if_b.resp_valid), 64'd0);
    if_b.bus_ack = 1'b1;
    step();
    check("rb_rv", 64'(if_b.resp_valid), 64'b0001);
    if_b.req_valid = '0;
    if_b.bus_ack = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
